// File: rtl/tube_arbiter.sv
// Three-way arbiter choosing which requester's 32-bit word drives the seven-segment tube.
// A granted word is held for HOLD_CYCLES before others may take over; the owner may refresh meanwhile.
module tube_arbiter #(
  parameter logic [31:0] HOLD_CYCLES = 32'd50000000,
  parameter logic [31:0] IDLE_DATA   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [31:0] req_data2,
  output logic [2:0]  req_ready,
  output logic [31:0] show_data,
  output logic [1:0]  owner,
  output logic        hold_active
);

  typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] show_q;
  logic [1:0]  owner_q;
  logic [1:0]  last_q;
  logic        hold_q;

  logic [1:0]  rr_start;
  logic [2:0]  rr_pos;
  logic [1:0]  rr_idx;
  logic        rr_found;
  logic [2:0]  ready_d;
  logic        transfer;
  logic [1:0]  grant_idx;
  logic [31:0] grant_data;

  // Round-robin search begins just after the last granted index, so the current owner comes last.
  always_comb begin
    rr_start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    rr_pos   = 3'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rr_pos = {1'b0, rr_start} + k[2:0];
      if (rr_pos >= 3'd3) begin
        rr_pos = rr_pos - 3'd3;
      end
      if (!rr_found && req_valid[rr_pos[1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_pos[1:0];
      end
    end
  end

  always_comb begin
    ready_d = 3'b000;
    if (!rst) begin
      case (state_q)
        SHOW: begin
          if (cnt_q != 32'd0) begin
            if (req_valid[owner_q]) begin
              ready_d[owner_q] = 1'b1;
            end
          end else if (rr_found) begin
            ready_d[rr_idx] = 1'b1;
          end
        end
        default: begin
          if (rr_found) begin
            ready_d[rr_idx] = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    transfer  = |ready_d;
    grant_idx = ready_d[1] ? 2'd1 : (ready_d[2] ? 2'd2 : 2'd0);
    case (grant_idx)
      2'd1:    grant_data = req_data1;
      2'd2:    grant_data = req_data2;
      default: grant_data = req_data0;
    endcase
    if (transfer) begin
      cnt_d = HOLD_CYCLES - 32'd1;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      show_q  <= IDLE_DATA;
      owner_q <= 2'd3;
      cnt_q   <= 32'd0;
      last_q  <= 2'd2;
      hold_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= (cnt_d != 32'd0);
      if (transfer) begin
        state_q <= SHOW;
        show_q  <= grant_data;
        owner_q <= grant_idx;
        last_q  <= grant_idx;
      end else if (state_q == SHOW && cnt_q == 32'd0) begin
        state_q <= LINGER;
      end
    end
  end

  assign req_ready   = ready_d;
  assign show_data   = show_q;
  assign owner       = owner_q;
  assign hold_active = hold_q;

endmodule

// File: tb/tb_tube_arbiter.sv
// Directed bench for tube_arbiter with HOLD_CYCLES=4: grant, hold window, refresh, linger,
// rotation and reset behaviour, each scenario checking against hand-computed values.
module tb_tube_arbiter;

  localparam logic [31:0] D0 = 32'hA0000000;
  localparam logic [31:0] D1 = 32'hB1111111;
  localparam logic [31:0] D2 = 32'hC2222222;
  localparam logic [31:0] DR = 32'h12345678;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic [31:0] req_data2;
  logic [2:0]  req_ready;
  logic [31:0] show_data;
  logic [1:0]  owner;
  logic        hold_active;

  int checks = 0;
  int errors = 0;

  tube_arbiter #(
    .HOLD_CYCLES(32'd4),
    .IDLE_DATA  (32'h00000000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_data2  (req_data2),
    .req_ready  (req_ready),
    .show_data  (show_data),
    .owner      (owner),
    .hold_active(hold_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v);
    req_valid = v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'b111);
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready got %b exp 000", req_ready);
    end
    step();
    step();
    checks++;
    if (show_data !== 32'h0 || owner !== 2'd3 || hold_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got show=%h owner=%0d hold=%b exp show=0 owner=3 hold=0",
               show_data, owner, hold_active);
    end
    drive(3'b000);
    rst = 1'b0;
    #1;
    $display("reset: show=%h owner=%0d", show_data, owner);
  endtask

  task automatic test_first_grant();
    drive(3'b111);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL first_ready got %b exp 001", req_ready);
    end
    step();
    checks++;
    if (show_data !== D0 || owner !== 2'd0 || hold_active !== 1'b1) begin
      errors++;
      $display("FAIL first_grant got show=%h owner=%0d hold=%b exp show=%h owner=0 hold=1",
               show_data, owner, hold_active, D0);
    end
    $display("grant: owner=%0d show=%h", owner, show_data);
  endtask

  // Edge index (counted from the last transfer) at which the pending valid set is accepted.
  task automatic wait_handover(input logic [2:0] want, output int n);
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      if (req_ready === want) begin
        n = c;
        break;
      end
      step();
    end
  endtask

  task automatic test_hold_handover();
    int n;
    drive(3'b010);
    wait_handover(3'b010, n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL handover_delay got %0d exp 4", n);
    end
    step();
    checks++;
    if (owner !== 2'd1 || show_data !== D1 || hold_active !== 1'b1) begin
      errors++;
      $display("FAIL handover_owner got owner=%0d show=%h hold=%b exp owner=1 show=%h hold=1",
               owner, show_data, hold_active, D1);
    end
    drive(3'b000);
    $display("handover: owner=%0d show=%h after %0d cycles", owner, show_data, n);
  endtask

  task automatic test_linger();
    step();
    step();
    step();
    checks++;
    if (hold_active !== 1'b0 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL expire got hold=%b ready=%b exp hold=0 ready=000", hold_active, req_ready);
    end
    step();
    step();
    checks++;
    if (show_data !== D1 || owner !== 2'd1 || hold_active !== 1'b0) begin
      errors++;
      $display("FAIL linger_keep got show=%h owner=%0d hold=%b exp show=%h owner=1 hold=0",
               show_data, owner, hold_active, D1);
    end
    drive(3'b100);
    checks++;
    if (req_ready !== 3'b100) begin
      errors++;
      $display("FAIL linger_ready got %b exp 100", req_ready);
    end
    step();
    checks++;
    if (owner !== 2'd2 || show_data !== D2 || hold_active !== 1'b1) begin
      errors++;
      $display("FAIL linger_grant got owner=%0d show=%h hold=%b exp owner=2 show=%h hold=1",
               owner, show_data, hold_active, D2);
    end
    drive(3'b000);
    $display("linger: regrant owner=%0d show=%h", owner, show_data);
  endtask

  task automatic test_refresh();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(3'b001);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL refresh_first got %b exp 001", req_ready);
    end
    step();
    drive(3'b000);
    step();
    req_data0 = DR;
    drive(3'b011);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL refresh_ready got %b exp 001", req_ready);
    end
    step();
    checks++;
    if (show_data !== DR || owner !== 2'd0 || hold_active !== 1'b1) begin
      errors++;
      $display("FAIL refresh_data got show=%h owner=%0d hold=%b exp show=%h owner=0 hold=1",
               show_data, owner, hold_active, DR);
    end
    drive(3'b010);
    wait_handover(3'b010, n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL refresh_delay got %0d exp 4", n);
    end
    step();
    checks++;
    if (owner !== 2'd1) begin
      errors++;
      $display("FAIL refresh_handover got owner=%0d exp 1", owner);
    end
    drive(3'b000);
    req_data0 = D0;
    $display("refresh: handover %0d cycles after refresh", n);
  endtask

  // Others keep requesting; the just-served requester drops its valid so the window can expire.
  task automatic test_rotation();
    logic [1:0] cur;
    logic [1:0] nxt;
    logic [2:0] exp_r;
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(3'b111);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL rot_first got %b exp 001", req_ready);
    end
    step();
    cur = 2'd0;
    for (int g = 0; g < 3; g++) begin
      nxt = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
      drive(3'b111 & ~(3'b001 << cur));
      for (int c = 1; c <= 4; c++) begin
        exp_r = (c == 4) ? (3'b001 << nxt) : 3'b000;
        checks++;
        if (req_ready !== exp_r) begin
          errors++;
          $display("FAIL rot_ready g%0d c%0d got %b exp %b", g, c, req_ready, exp_r);
        end
        step();
      end
      checks++;
      if (owner !== nxt) begin
        errors++;
        $display("FAIL rot_owner g%0d got %0d exp %0d", g, owner, nxt);
      end
      $display("rotation: owner=%0d show=%h", owner, show_data);
      cur = nxt;
    end
  endtask

  task automatic test_reset_mid();
    drive(3'b111);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_ready got %b exp 000", req_ready);
    end
    step();
    checks++;
    if (show_data !== 32'h0 || owner !== 2'd3 || hold_active !== 1'b0 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_state got show=%h owner=%0d hold=%b ready=%b exp 0/3/0/000",
               show_data, owner, hold_active, req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_release got %b exp 001", req_ready);
    end
    step();
    checks++;
    if (owner !== 2'd0 || show_data !== D0) begin
      errors++;
      $display("FAIL rstmid_grant got owner=%0d show=%h exp owner=0 show=%h", owner, show_data, D0);
    end
    drive(3'b000);
    $display("reset_mid: owner=%0d", owner);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 3'b000;
    req_data0 = D0;
    req_data1 = D1;
    req_data2 = D2;
    step();
    test_reset();
    test_first_grant();
    test_hold_handover();
    test_linger();
    test_refresh();
    test_rotation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
